// File: rtl/bcd_scan_ctrl.sv
// bcd_scan_ctrl: time-multiplexing scheduler for a 74LS42-style BCD-to-decimal
// decoder. Cycles through the enabled channels and holds each one for DWELL
// cycles. Between channels it inserts BLANK cycles of code 4'hF, which drives
// every decoder output high.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   en         scan enable; low forces IDLE
//   hold       (only with BCD_SCAN_HOLD_EN) freezes the dwell/gap counter
//   ch_mask    per-channel enable, bit i selects decimal output Yi
//   D,C,B,A    BCD code to the decoder (registered)
//   active     high while a channel code 0..9 is driven
//   ch_idx     index of the last driven channel
//   frame_done one-cycle pulse after the final dwell of a frame
//
// Optional feature macro: BCD_SCAN_HOLD_EN (adds the hold input).
module bcd_scan_ctrl #(
    parameter int unsigned NUM_CH = 10,
    parameter int unsigned DWELL  = 1000,
    parameter int unsigned BLANK  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
`ifdef BCD_SCAN_HOLD_EN
    input  logic       hold,
`endif
    input  logic [9:0] ch_mask,
    output logic       D,
    output logic       C,
    output logic       B,
    output logic       A,
    output logic       active,
    output logic [3:0] ch_idx,
    output logic       frame_done
);

    localparam int unsigned NCH_MAX  = 10;
    localparam bit          HAS_BLANK = (BLANK > 0);
    localparam int unsigned MAX_LOAD = (DWELL > BLANK) ? DWELL : BLANK;
    localparam int unsigned CNT_W    = (MAX_LOAD > 1) ? $clog2(MAX_LOAD) : 1;
    localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL - 1);
    localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(HAS_BLANK ? BLANK - 1 : 0);
    localparam logic [9:0]  MASK_VALID = 10'((1 << NUM_CH) - 1);
    localparam logic [3:0]  CODE_OFF   = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_BLANK
    } state_t;

    state_t           state;
    logic [3:0]       code;
    logic [CNT_W-1:0] cnt;

    logic [9:0] emask;
    logic       any_en;
    logic [3:0] first_ch;
    logic [3:0] above_ch;
    logic       above_found;
    logic [3:0] nxt_ch;
    logic       hold_i;
    logic       dwell_end;

`ifdef BCD_SCAN_HOLD_EN
    assign hold_i = hold;
`else
    assign hold_i = 1'b0;
`endif

    assign {D, C, B, A} = code;

    // Channel selection: lowest enabled channel, and the next one above ch_idx
    always_comb begin
        emask       = ch_mask & MASK_VALID;
        any_en      = |emask;
        first_ch    = 4'd0;
        above_ch    = 4'd0;
        above_found = 1'b0;
        for (int i = NCH_MAX - 1; i >= 0; i--) begin
            if (emask[i]) begin
                first_ch = 4'(i);
                if (4'(i) > ch_idx) begin
                    above_ch    = 4'(i);
                    above_found = 1'b1;
                end
            end
        end
        nxt_ch = above_found ? above_ch : first_ch;
    end

    // A cleared mask bit cuts the dwell short even while held
    assign dwell_end = (!hold_i && cnt == '0) || !emask[ch_idx];

    // Scan FSM with registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            code       <= CODE_OFF;
            active     <= 1'b0;
            ch_idx     <= 4'd0;
            frame_done <= 1'b0;
            cnt        <= '0;
        end else begin
            frame_done <= 1'b0;
            if (!en) begin
                state  <= ST_IDLE;
                code   <= CODE_OFF;
                active <= 1'b0;
                cnt    <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        code   <= CODE_OFF;
                        active <= 1'b0;
                        if (any_en) begin
                            state  <= ST_DRIVE;
                            code   <= first_ch;
                            active <= 1'b1;
                            ch_idx <= first_ch;
                            cnt    <= DWELL_LOAD;
                        end
                    end
                    ST_DRIVE: begin
                        if (dwell_end) begin
                            // No enabled channel above this one: the frame wraps
                            frame_done <= !above_found;
                            if (HAS_BLANK) begin
                                state  <= ST_BLANK;
                                code   <= CODE_OFF;
                                active <= 1'b0;
                                cnt    <= BLANK_LOAD;
                            end else if (any_en) begin
                                code   <= nxt_ch;
                                ch_idx <= nxt_ch;
                                cnt    <= DWELL_LOAD;
                            end else begin
                                state  <= ST_IDLE;
                                code   <= CODE_OFF;
                                active <= 1'b0;
                                cnt    <= '0;
                            end
                        end else if (!hold_i) begin
                            cnt <= cnt - CNT_W'(1);
                        end
                    end
                    ST_BLANK: begin
                        if (!hold_i && cnt == '0) begin
                            if (any_en) begin
                                state  <= ST_DRIVE;
                                code   <= nxt_ch;
                                active <= 1'b1;
                                ch_idx <= nxt_ch;
                                cnt    <= DWELL_LOAD;
                            end else begin
                                state <= ST_IDLE;
                                cnt   <= '0;
                            end
                        end else if (!hold_i) begin
                            cnt <= cnt - CNT_W'(1);
                        end
                    end
                    default: begin
                        state  <= ST_IDLE;
                        code   <= CODE_OFF;
                        active <= 1'b0;
                        cnt    <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bcd_scan_ctrl.sv
// Scoreboard bench for bcd_scan_ctrl. Two instances share one set of inputs.
// The first instance has blanking and 6 channels. The second has no blanking,
// a 1-cycle dwell and 10 channels. A behavioural model predicts every cycle,
// and a monitor process compares the predictions with the DUT outputs.
module tb_bcd_scan_ctrl;

    localparam int NC0 = 6,  DW0 = 4, BL0 = 2;
    localparam int NC1 = 10, DW1 = 1, BL1 = 0;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       hold;
    logic [9:0] ch_mask;

    logic d0, c0, b0, a0, act0, fd0;
    logic d1, c1, b1, a1, act1, fd1;
    logic [3:0] idx0, idx1;

    always #5 clk = ~clk;

    bcd_scan_ctrl #(.NUM_CH(NC0), .DWELL(DW0), .BLANK(BL0)) u_dut0 (
        .clk(clk), .rst(rst), .en(en),
`ifdef BCD_SCAN_HOLD_EN
        .hold(hold),
`endif
        .ch_mask(ch_mask), .D(d0), .C(c0), .B(b0), .A(a0),
        .active(act0), .ch_idx(idx0), .frame_done(fd0)
    );

    bcd_scan_ctrl #(.NUM_CH(NC1), .DWELL(DW1), .BLANK(BL1)) u_dut1 (
        .clk(clk), .rst(rst), .en(en),
`ifdef BCD_SCAN_HOLD_EN
        .hold(hold),
`endif
        .ch_mask(ch_mask), .D(d1), .C(c1), .B(b1), .A(a1),
        .active(act1), .ch_idx(idx1), .frame_done(fd1)
    );

    // phase: 0 idle, 1 showing channel ch, 2 blank gap; rem = cycles left incl. current
    typedef struct {
        int phase;
        int ch;
        int rem;
        bit fd;
    } mst_t;

    typedef struct packed {
        logic [3:0] code;
        logic       act;
        logic [3:0] idx;
        logic       fd;
    } obs_t;

    obs_t q0[$];
    obs_t q1[$];
    mst_t m0, m1;
    int   checks = 0;
    int   failures = 0;

    function automatic int emask_of(logic [9:0] m, int nch);
        int r = 0;
        for (int i = 0; i < nch; i++) if (m[i]) r = r | (1 << i);
        return r;
    endfunction

    // Next enabled channel after ch going round the ring; wrap when it is not above ch
    function automatic int next_of(int em, int ch, int nch, output bit wrap);
        wrap = 1'b1;
        for (int k = 1; k <= nch; k++) begin
            int c;
            c = (ch + k) % nch;
            if (em[c]) begin
                wrap = (c <= ch);
                return c;
            end
        end
        return 0;
    endfunction

    function automatic mst_t mstep(mst_t s, int nch, int dw, int bl,
                                   logic r, logic e, logic h, logic [9:0] m);
        mst_t n;
        int   em, nx, lo;
        bit   wr, wr_lo;
        n    = s;
        n.fd = 1'b0;
        em   = emask_of(m, nch);
        nx   = next_of(em, s.ch, nch, wr);
        lo   = next_of(em, nch - 1, nch, wr_lo);
        if (r) begin
            n.phase = 0; n.ch = 0; n.rem = 0;
        end else if (!e) begin
            n.phase = 0; n.rem = 0;
        end else if (s.phase == 0) begin
            if (em != 0) begin n.phase = 1; n.ch = lo; n.rem = dw; end
        end else if (s.phase == 1) begin
            if (em[s.ch] == 1'b0 || (!h && s.rem == 1)) begin
                n.fd = wr;
                if (bl > 0) begin n.phase = 2; n.rem = bl; end
                else if (em != 0) begin n.ch = nx; n.rem = dw; end
                else begin n.phase = 0; n.rem = 0; end
            end else if (!h) begin
                n.rem = s.rem - 1;
            end
        end else begin
            if (!h && s.rem == 1) begin
                if (em != 0) begin n.phase = 1; n.ch = nx; n.rem = dw; end
                else begin n.phase = 0; n.rem = 0; end
            end else if (!h) begin
                n.rem = s.rem - 1;
            end
        end
        return n;
    endfunction

    function automatic obs_t obs_of(mst_t s);
        obs_t o;
        o.code = (s.phase == 1) ? 4'(s.ch) : 4'hF;
        o.act  = (s.phase == 1);
        o.idx  = 4'(s.ch);
        o.fd   = s.fd;
        return o;
    endfunction

    // Apply inputs for the next edge and queue the outputs expected after it
    task automatic step_cycle(input logic r, input logic e, input logic h, input logic [9:0] m);
        @(posedge clk);
        #2;
        rst = r; en = e; hold = h; ch_mask = m;
        m0 = mstep(m0, NC0, DW0, BL0, r, e, h, m);
        m1 = mstep(m1, NC1, DW1, BL1, r, e, h, m);
        q0.push_back(obs_of(m0));
        q1.push_back(obs_of(m1));
    endtask

    task automatic check_reset_now(input string name);
        obs_t g0, g1;
        g0 = {d0, c0, b0, a0, act0, idx0, fd0};
        g1 = {d1, c1, b1, a1, act1, idx1, fd1};
        checks++;
        if (g0 !== {4'hF, 1'b0, 4'h0, 1'b0}) begin
            failures++;
            $display("FAIL %s dut0 got=%h want=%h", name, g0, {4'hF, 1'b0, 4'h0, 1'b0});
        end
        checks++;
        if (g1 !== {4'hF, 1'b0, 4'h0, 1'b0}) begin
            failures++;
            $display("FAIL %s dut1 got=%h want=%h", name, g1, {4'hF, 1'b0, 4'h0, 1'b0});
        end
    endtask

    // Monitor: every cycle compares DUT outputs with the oldest queued prediction
    initial begin
        obs_t e, g;
        forever begin
            @(posedge clk);
            #1;
            if (q0.size() > 0) begin
                e = q0.pop_front();
                g = {d0, c0, b0, a0, act0, idx0, fd0};
                checks++;
                if (g !== e) begin
                    failures++;
                    $display("FAIL scan0 t=%0t got code=%h act=%b idx=%0d fd=%b want code=%h act=%b idx=%0d fd=%b",
                             $time, g.code, g.act, g.idx, g.fd, e.code, e.act, e.idx, e.fd);
                end
            end
            if (q1.size() > 0) begin
                e = q1.pop_front();
                g = {d1, c1, b1, a1, act1, idx1, fd1};
                checks++;
                if (g !== e) begin
                    failures++;
                    $display("FAIL scan1 t=%0t got code=%h act=%b idx=%0d fd=%b want code=%h act=%b idx=%0d fd=%b",
                             $time, g.code, g.act, g.idx, g.fd, e.code, e.act, e.idx, e.fd);
                end
            end
        end
    end

    initial begin
        logic [9:0] mask;
        logic       e, h, r;
        bit         found;

        m0 = '{0, 0, 0, 1'b0};
        m1 = '{0, 0, 0, 1'b0};
        rst = 1'b0; en = 1'b0; hold = 1'b0; ch_mask = 10'h000;
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #3;
        check_reset_now("reset_state");

        // Idle with en low, mask full
        for (int i = 0; i < 8; i++) step_cycle(1'b0, 1'b0, 1'b0, 10'h3FF);

        // Basic scan of channels 0 and 2
        for (int i = 0; i < 36; i++) step_cycle(1'b0, 1'b1, 1'b0, 10'b0000000101);

        // Truncation: clear bit 2 during the second cycle of the ch2 dwell
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            step_cycle(1'b0, 1'b1, 1'b0, 10'b0000000101);
            if (m0.phase == 1 && m0.ch == 2 && m0.rem == DW0 - 1) found = 1'b1;
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL trunc_setup got=not_reached want=ch2_second_cycle");
        end
        step_cycle(1'b0, 1'b1, 1'b0, 10'b0000000001);
        for (int i = 0; i < 12; i++) step_cycle(1'b0, 1'b1, 1'b0, 10'b0000000101);

        // Mask bits beyond NUM_CH are ignored, then only channel 5
        for (int i = 0; i < 16; i++) step_cycle(1'b0, 1'b1, 1'b0, 10'h3C0);
        for (int i = 0; i < 30; i++) step_cycle(1'b0, 1'b1, 1'b0, 10'h3E0);

        // Full mask, then async reset in the middle of a cycle
        for (int i = 0; i < 7; i++) step_cycle(1'b0, 1'b1, 1'b0, 10'h3FF);
        step_cycle(1'b1, 1'b1, 1'b0, 10'h3FF);
        #1;
        check_reset_now("async_reset");
        for (int i = 0; i < 25; i++) step_cycle(1'b0, 1'b1, 1'b0, 10'h3FF);

`ifdef BCD_SCAN_HOLD_EN
        // Hold channel 3 for 20 cycles
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            step_cycle(1'b0, 1'b1, 1'b0, 10'h008);
            if (m0.phase == 1 && m0.ch == 3) found = 1'b1;
        end
        for (int i = 0; i < 20; i++) step_cycle(1'b0, 1'b1, 1'b1, 10'h008);
        for (int i = 0; i < 12; i++) step_cycle(1'b0, 1'b1, 1'b0, 10'h008);
`endif

        // Randomised traffic
        mask = 10'h0A5;
        h    = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(29, 0) == 0) mask = 10'($urandom_range(1023, 0));
            e = ($urandom_range(49, 0) != 0);
            r = ($urandom_range(399, 0) == 0);
`ifdef BCD_SCAN_HOLD_EN
            if ($urandom_range(7, 0) == 0) h = ~h;
`endif
            step_cycle(r, e, h, mask);
        end

        @(posedge clk);
        #3;
        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            failures++;
            $display("FAIL drain got=%0d/%0d want=0/0", q0.size(), q1.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bcd_scan_ctrl.md
Name: bcd_scan_ctrl

Overview:
Time-multiplexing scheduler for the 74LS42-style BCD-to-decimal decoder in the digital clock IP set.
- Drives the decoder's D,C,B,A inputs so that one active-low decimal output (one display digit or column select) is on at a time.
- Visits only the channels enabled in a mask, holding each for a programmable dwell time.
- Inserts a blanking gap (code 4'hF, all decoder outputs high) between channels to prevent ghosting.

Parameters:
- NUM_CH, 10, number of scannable channels, 1..10. Mask bits at index >= NUM_CH are ignored.
- DWELL, 1000, clock cycles each channel is driven, >= 1.
- BLANK, 2, clock cycles of blank code between channels, >= 0. A value of 0 removes the BLANK state.

Ports:
- clk, input, 1, system clock; all state updates on its rising edge.
- rst, input, 1, asynchronous active-high reset.
- en, input, 1, scan enable.
- ch_mask, input, 10, per-channel enable; bit i enables decimal output Yi.
- D, output, 1, BCD bit 3 to decoder.
- C, output, 1, BCD bit 2 to decoder.
- B, output, 1, BCD bit 1 to decoder.
- A, output, 1, BCD bit 0 to decoder.
- active, output, 1, high while a channel code (0..9) is being driven.
- ch_idx, output, 4, index of the last driven channel.
- frame_done, output, 1, one-cycle pulse per completed scan frame.

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-high.
- Outputs: all are registered; no combinational path from inputs to outputs.
- Reset values: state IDLE, {D,C,B,A}=4'hF, active=0, ch_idx=0, frame_done=0, dwell/gap counter=0.
- Effective mask: emask = ch_mask & ((1<<NUM_CH)-1).
- next(i): lowest set bit of emask above i. If none exists, wrap to the lowest set bit overall (wrap=1).

States:
- IDLE:
  - Outputs 4'hF, active=0.
  - If en=1 and emask!=0, go to DRIVE on the lowest set bit.
  - On entry to DRIVE: D..A=channel, active=1, ch_idx=channel, counter=DWELL-1.
  - The first drive cycle is the cycle after the edge that samples en=1.
- DRIVE:
  - Counter decrements each cycle. When the counter reaches 0, leave DRIVE: exactly DWELL cycles are driven.
  - If BLANK>0: go to BLANK, code 4'hF, active=0, counter=BLANK-1.
  - If BLANK=0: go directly to DRIVE on next(ch_idx), with no blank cycle.
- BLANK:
  - Counter decrements each cycle. At 0, go to DRIVE on next(ch_idx), selected from emask as sampled on that edge.
  - If emask=0 at that edge, go to IDLE.

Frame and boundary rules:
- frame_done: asserted for the single cycle immediately after the final DRIVE cycle of a channel whose next() wrapped. A single enabled channel pulses after every dwell.
- en=0 in any state: next cycle IDLE, code 4'hF, active=0. An in-progress dwell is abandoned and no frame_done is issued.
- Current channel's mask bit cleared during DRIVE: dwell is truncated; the next cycle behaves as the end of dwell (BLANK or next channel).
- emask goes 0 during DRIVE: this is the truncation case; the block then reaches IDLE after BLANK (or immediately if BLANK=0).
- Mask bits set mid-frame: take effect at the next channel selection.
- rst asserted mid-operation: outputs return to reset values immediately (asynchronous); scanning restarts from the lowest enabled channel.
- Driven codes are always 0..9 or 4'hF; codes 10..14 are never produced.

Optional Feature:
- Macro: BCD_SCAN_HOLD_EN.
- With the macro defined:
  - Adds input port hold, width 1.
  - While hold=1 in DRIVE, the counter freezes and the current channel stays driven indefinitely.
  - While hold=1 in BLANK, the counter also freezes.
  - Releasing hold resumes the count from the frozen value.
  - en=0, rst and mask truncation still override hold.
- Without the macro: no hold port; the counter always runs.

Test Plan:
- Reset/idle: rst=1, then rst=0, en=0 -> D..A=4'hF, active=0, frame_done=0 indefinitely.
- Basic scan: DWELL=4, BLANK=2, ch_mask=10'b0000000101, en=1 -> repeating pattern of ch0 ×4, F ×2, ch2 ×4, F ×2; period 12 cycles; frame_done pulses once per period, on the cycle after the last ch2 cycle.
- No blank with full mask: BLANK=0, DWELL=1, ch_mask=10'h3FF -> code steps 0,1,...,9,0 every cycle; frame_done pulses every 10 cycles; active is constantly 1.
- Truncation: during ch2 dwell cycle 2, clear mask bit 2 -> next cycle is blank; ch0 follows after BLANK cycles.
- NUM_CH and masking: NUM_CH=6, ch_mask=10'h3C0 -> stays IDLE with 4'hF. Then set mask to 10'h3E0 -> only channel 5 is scanned, and frame_done follows every dwell.
- Async reset and hold: assert rst mid-DRIVE -> D..A=4'hF within the same cycle. Separately, with BCD_SCAN_HOLD_EN defined, hold=1 for 20 cycles on ch3 -> ch3 stays driven for DWELL+20 cycles in total.
